exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the 5-stage MIPS pipeline. Takes decoded operands and control from the ID/EX boundary, computes single-cycle ALU results or runs an iterative 32-cycle multiply/divide, and registers the EX/MEM boundary. Its outputs `ALU_result`, `ST_value`, `MEM_R_EN` and `MEM_W_EN` drive the memory stage directly. During multi-cycle ops it stalls upstream through `in_ready`.

## Interface
- `WIDTH`, 32, datapath width
- `REG_BITS`, 5, destination register index width
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low (0 = reset)
- `in_valid`  input  1  ID/EX presents a valid instruction
- `in_ready`  output  1  stage accepts this cycle; `(state == IDLE)`, combinational
- `flush`  input  1  branch-taken squash
- `EXE_CMD`  input  4  operation code
- `val1`, `val2`  input  WIDTH  forwarded operands
- `ST_val_in`  input  WIDTH  store data
- `dest_in`  input  REG_BITS  destination register
- `MEM_R_EN_in`, `MEM_W_EN_in`, `WB_EN_in`  input  1  control bits
- `out_valid`  output  1  EX/MEM holds a valid instruction
- `ALU_result`, `ST_value`  output  WIDTH  registered result and store data
- `dest`  output  REG_BITS  registered destination
- `MEM_R_EN`, `MEM_W_EN`, `WB_EN`  output  1  registered control, forced to 0 when `out_valid = 0`

## Operation
- `EXE_CMD` encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR
  - 6 SLL, 7 SRL, 8 SRA: shift amount is `val2[4:0]`
  - 9 SLT: signed compare, result 1 or 0
  - 10 MUL: low WIDTH bits of the product
  - 11 DIVU: unsigned quotient
  - 12 REMU: unsigned remainder
  - 13–15: result 0, control bits passed through
- Arithmetic wraps modulo 2^WIDTH. No overflow trap.
- FSM states: IDLE, BUSY.
  - IDLE with `in_valid && !flush` and a single-cycle op: the result and all input fields are registered and `out_valid` = 1.
  - IDLE with `in_valid && !flush` and cmd 10–12: operands and fields are latched, `out_valid` = 0, the iteration counter is cleared, and the state goes to BUSY.
  - BUSY: one iteration per cycle. When the counter reaches 31, the result is registered, `out_valid` = 1, and the state returns to IDLE.
  - IDLE with no accepted input: `out_valid` = 0 (bubble).
- Divide by zero: quotient = all ones, remainder = `val1`.
- Flush has priority over everything. At a flush edge: `out_valid` is cleared, any BUSY op is abandoned, the state goes to IDLE, and the input in that cycle is not accepted.
- Bubble rule: `MEM_R_EN`, `MEM_W_EN` and `WB_EN` are 0 whenever `out_valid` = 0. Data registers hold their last value.

## Timing
- Reset (asynchronous assert, synchronous release): `out_valid`, `ALU_result`, `ST_value`, `dest`, `MEM_R_EN`, `MEM_W_EN` and `WB_EN` are all 0, and the state is IDLE. `in_ready` reads 1, but nothing is captured while `reset` = 0.
- Single-cycle ops: accepted at edge t, outputs valid after edge t.
- Mul/div: accepted at edge t, result and `out_valid` after edge t+32. `in_ready` = 0 from after edge t until edge t+32. The next instruction is accepted at edge t+33 at the earliest.
- `out_valid` is high for exactly one cycle per accepted instruction. No downstream backpressure: the memory stage always consumes.
- Reset asserted mid-BUSY: immediate return to IDLE with all outputs at their reset values. The partial result is discarded.
- `flush` and the final BUSY iteration at the same edge: flush wins and no result is produced.

## Structure
- Shared package `exe_pkg` holds:
  - `EXE_CMD` constants
  - state encoding (IDLE/BUSY)
  - default `WIDTH` and `REG_BITS`
- Sub-module `seq_muldiv`: iterative shift-add multiplier and restoring divider.
  - Ports: `start`, `op`, `a`, `b`, `busy`, `done`, `result`.
  - 32 iterations; shares `clk`/`reset`.
- ALU and output registers sit in `exe_stage`.

## Test plan
- Reset held low with `in_valid` = 1: all outputs 0. Release, then ADD 5+7 → `ALU_result` = 12, `out_valid` = 1 one edge later.
- SUB 3−5 → 0xFFFFFFFE. SLT(−1, 1) → 1. SRA(0x80000000, 4) → 0xF8000000. cmd 14 → 0.
- MUL 0x10000×0x10000 → 0. MUL 1234×5678 → 7006652. `in_ready` = 0 for exactly 32 cycles, `out_valid` pulses once at t+32.
- DIVU 100/7 → 14, REMU → 2. DIVU x/0 → 0xFFFFFFFF, REMU x/0 → x.
- Flush at cycle 10 of a DIV: no `out_valid`, `in_ready` = 1 next cycle. A following ADD completes normally.
- Store (`MEM_W_EN_in` = 1) followed by a bubble: `MEM_W_EN` = 1 for one cycle, then 0, with `ST_value` unchanged.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage:
// operation codes, FSM states and default widths.
package exe_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_REG_BITS = 5;

  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_AND  = 4'd2;
  localparam logic [3:0] CMD_OR   = 4'd3;
  localparam logic [3:0] CMD_NOR  = 4'd4;
  localparam logic [3:0] CMD_XOR  = 4'd5;
  localparam logic [3:0] CMD_SLL  = 4'd6;
  localparam logic [3:0] CMD_SRL  = 4'd7;
  localparam logic [3:0] CMD_SRA  = 4'd8;
  localparam logic [3:0] CMD_SLT  = 4'd9;
  localparam logic [3:0] CMD_MUL  = 4'd10;
  localparam logic [3:0] CMD_DIVU = 4'd11;
  localparam logic [3:0] CMD_REMU = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] MD_MUL  = 2'd0;
  localparam logic [1:0] MD_DIVU = 2'd1;
  localparam logic [1:0] MD_REMU = 2'd2;

endpackage

// File: rtl/exe_seq_muldiv.sv
// Iterative shift-add multiplier and restoring divider.
// One bit per cycle; done/result are valid in the last cycle.
module seq_muldiv
  import exe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] x_n;
  logic [WIDTH-1:0] y_n;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH:0]   trial;

  // x: multiplicand / dividend-quotient, y: multiplier / divisor,
  // acc: partial product / partial remainder
  always_comb begin
    x_n   = x;
    y_n   = y;
    acc_n = acc;
    trial = {acc, x[WIDTH-1]} - {1'b0, y};
    if (op_q == MD_MUL) begin
      acc_n = acc + (y[0] ? x : '0);
      x_n   = x << 1;
      y_n   = y >> 1;
    end else if (!trial[WIDTH]) begin
      acc_n = trial[WIDTH-1:0];
      x_n   = {x[WIDTH-2:0], 1'b1};
    end else begin
      acc_n = {acc[WIDTH-2:0], x[WIDTH-1]};
      x_n   = {x[WIDTH-2:0], 1'b0};
    end
  end

  assign done   = busy && (cnt == LAST);
  assign result = (op_q == MD_DIVU) ? x_n : acc_n;

  // Start latches operands; each busy cycle runs one iteration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      op_q <= MD_MUL;
      x    <= '0;
      y    <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      op_q <= op;
      x    <= a;
      y    <= b;
      acc  <= '0;
    end else if (busy) begin
      x   <= x_n;
      y   <= y_n;
      acc <= acc_n;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: single-cycle ALU, iterative mul/div,
// and the EX/MEM pipeline register.
module exe_stage
  import exe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REG_BITS = DEF_REG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  input  logic [3:0]          EXE_CMD,
  input  logic [WIDTH-1:0]    val1,
  input  logic [WIDTH-1:0]    val2,
  input  logic [WIDTH-1:0]    ST_val_in,
  input  logic [REG_BITS-1:0] dest_in,
  input  logic                MEM_R_EN_in,
  input  logic                MEM_W_EN_in,
  input  logic                WB_EN_in,
  output logic                out_valid,
  output logic [WIDTH-1:0]    ALU_result,
  output logic [WIDTH-1:0]    ST_value,
  output logic [REG_BITS-1:0] dest,
  output logic                MEM_R_EN,
  output logic                MEM_W_EN,
  output logic                WB_EN
);

  state_t state;

  logic [WIDTH-1:0]    alu;
  logic [4:0]          sh;
  logic                is_md;
  logic                md_start;
  logic [1:0]          md_op;
  logic                md_busy;
  logic                md_done;
  logic                md_fin;
  logic [WIDTH-1:0]    md_result;

  logic [WIDTH-1:0]    p_st;
  logic [REG_BITS-1:0] p_dest;
  logic                p_r;
  logic                p_w;
  logic                p_wb;

  assign in_ready = (state == IDLE);
  assign sh       = val2[4:0];
  assign is_md    = (EXE_CMD == CMD_MUL) ||
                    (EXE_CMD == CMD_DIVU) ||
                    (EXE_CMD == CMD_REMU);
  assign md_op    = 2'(EXE_CMD - CMD_MUL);
  assign md_start = in_ready && in_valid && !flush && is_md;
  assign md_fin   = (state == BUSY) && md_busy && md_done;

  // Single-cycle result; unused codes produce zero
  always_comb begin
    alu = '0;
    case (EXE_CMD)
      CMD_ADD: alu = val1 + val2;
      CMD_SUB: alu = val1 - val2;
      CMD_AND: alu = val1 & val2;
      CMD_OR:  alu = val1 | val2;
      CMD_NOR: alu = ~(val1 | val2);
      CMD_XOR: alu = val1 ^ val2;
      CMD_SLL: alu = val1 << sh;
      CMD_SRL: alu = val1 >> sh;
      CMD_SRA: alu = $signed(val1) >>> sh;
      CMD_SLT: alu = {{(WIDTH-1){1'b0}},
                      $signed(val1) < $signed(val2)};
      default: alu = '0;
    endcase
  end

  seq_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (md_op),
    .a     (val1),
    .b     (val2),
    .busy  (md_busy),
    .done  (md_done),
    .result(md_result)
  );

  // Control FSM and EX/MEM register; flush beats everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      ALU_result <= '0;
      ST_value   <= '0;
      dest       <= '0;
      MEM_R_EN   <= 1'b0;
      MEM_W_EN   <= 1'b0;
      WB_EN      <= 1'b0;
      p_st       <= '0;
      p_dest     <= '0;
      p_r        <= 1'b0;
      p_w        <= 1'b0;
      p_wb       <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      MEM_R_EN  <= 1'b0;
      MEM_W_EN  <= 1'b0;
      WB_EN     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      MEM_R_EN  <= 1'b0;
      MEM_W_EN  <= 1'b0;
      WB_EN     <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && is_md) begin
            state  <= BUSY;
            p_st   <= ST_val_in;
            p_dest <= dest_in;
            p_r    <= MEM_R_EN_in;
            p_w    <= MEM_W_EN_in;
            p_wb   <= WB_EN_in;
          end else if (in_valid) begin
            out_valid  <= 1'b1;
            ALU_result <= alu;
            ST_value   <= ST_val_in;
            dest       <= dest_in;
            MEM_R_EN   <= MEM_R_EN_in;
            MEM_W_EN   <= MEM_W_EN_in;
            WB_EN      <= WB_EN_in;
          end
        end
        BUSY: begin
          if (md_fin) begin
            state      <= IDLE;
            out_valid  <= 1'b1;
            ALU_result <= md_result;
            ST_value   <= p_st;
            dest       <= p_dest;
            MEM_R_EN   <= p_r;
            MEM_W_EN   <= p_w;
            WB_EN      <= p_wb;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage:
// scoreboard of expected EX/MEM words plus scenario tasks.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [3:0]  EXE_CMD;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] ST_val_in;
  logic [4:0]  dest_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  logic        WB_EN_in;
  logic        out_valid;
  logic [31:0] ALU_result;
  logic [31:0] ST_value;
  logic [4:0]  dest;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic        WB_EN;

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  d;
    logic        r;
    logic        w;
    logic        wb;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  exe_stage #(
    .WIDTH(32),
    .REG_BITS(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .EXE_CMD    (EXE_CMD),
    .val1       (val1),
    .val2       (val2),
    .ST_val_in  (ST_val_in),
    .dest_in    (dest_in),
    .MEM_R_EN_in(MEM_R_EN_in),
    .MEM_W_EN_in(MEM_W_EN_in),
    .WB_EN_in   (WB_EN_in),
    .out_valid  (out_valid),
    .ALU_result (ALU_result),
    .ST_value   (ST_value),
    .dest       (dest),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .WB_EN      (WB_EN)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model(
    input logic [3:0] c, input logic [31:0] a, b);
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return ~(a | b);
      4'd5:  return a ^ b;
      4'd6:  return a << b[4:0];
      4'd7:  return a >> b[4:0];
      4'd8:  return $unsigned($signed(a) >>> b[4:0]);
      4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: return a * b;
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard consumer: pop on every valid output, bubble rule otherwise
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (out_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out got res=%h dest=%0d",
                   ALU_result, dest);
        end else begin
          e = sb.pop_front();
          if ({ALU_result, ST_value, dest, MEM_R_EN, MEM_W_EN, WB_EN}
              !== {e.res, e.st, e.d, e.r, e.w, e.wb}) begin
            n_err++;
            $display("FAIL sb_out got %h/%h/%0d/%b%b%b want %h/%h/%0d/%b%b%b",
                     ALU_result, ST_value, dest, MEM_R_EN, MEM_W_EN, WB_EN,
                     e.res, e.st, e.d, e.r, e.w, e.wb);
          end
        end
      end else begin
        n_cmp++;
        if ({MEM_R_EN, MEM_W_EN, WB_EN} !== 3'b000) begin
          n_err++;
          $display("FAIL bubble_ctrl got %b%b%b want 000",
                   MEM_R_EN, MEM_W_EN, WB_EN);
        end
      end
    end
  end

  task automatic send(
    input logic [3:0] c, input logic [31:0] a, b, st,
    input logic [4:0] d, input logic r, w, wb,
    input logic [31:0] exp, input bit keep);
    EXE_CMD     = c;
    val1        = a;
    val2        = b;
    ST_val_in   = st;
    dest_in     = d;
    MEM_R_EN_in = r;
    MEM_W_EN_in = w;
    WB_EN_in    = wb;
    in_valid    = 1'b1;
    if (keep) sb.push_back('{exp, st, d, r, w, wb});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_timeout got in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b1;
    EXE_CMD     = 4'd0;
    val1        = 32'd5;
    val2        = 32'd7;
    ST_val_in   = 32'h1234_5678;
    dest_in     = 5'd9;
    MEM_R_EN_in = 1'b1;
    MEM_W_EN_in = 1'b1;
    WB_EN_in    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, ALU_result, ST_value, dest,
         MEM_R_EN, MEM_W_EN, WB_EN, in_ready} !== {72'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state got ov=%b res=%h st=%h d=%0d ctrl=%b%b%b rdy=%b want zeros rdy=1",
               out_valid, ALU_result, ST_value, dest,
               MEM_R_EN, MEM_W_EN, WB_EN, in_ready);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    send(4'd0, 32'd5, 32'd7, 32'd0, 5'd3, 0, 0, 1, 32'd12, 1);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || ALU_result !== 32'd12) begin
      n_err++;
      $display("FAIL add_latency got ov=%b res=%h want ov=1 res=0000000c",
               out_valid, ALU_result);
    end
    @(posedge clk);
    #1;
    send(4'd1, 32'd3, 32'd5, 32'd0, 5'd4, 0, 0, 1, 32'hFFFF_FFFE, 1);
    send(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd5, 0, 0, 1, 32'd1, 1);
    send(4'd8, 32'h8000_0000, 32'd4, 32'd0, 5'd6, 0, 0, 1,
         32'hF800_0000, 1);
    send(4'd14, 32'hAAAA_5555, 32'd9, 32'h77, 5'd7, 1, 0, 1, 32'd0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_alu();
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      c = 4'($urandom_range(0, 12));
      if (c >= 4'd10) c = c + 4'd3;
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      send(c, a, b, $urandom, 5'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), model(c, a, b), 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul();
    int low;
    bit early;
    low   = 0;
    early = 0;
    send(4'd10, 32'd1234, 32'd5678, 32'h55, 5'd8, 0, 0, 1,
         32'd7006652, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      low++;
      if (out_valid) early = 1;
    end
    n_cmp++;
    if (low != 32 || early || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mul_timing got low=%0d early=%0b ov=%b want low=32 early=0 ov=1",
               low, early, out_valid);
    end
    @(posedge clk);
    #1;
    send(4'd10, 32'h1_0000, 32'h1_0000, 32'd0, 5'd9, 0, 0, 1, 32'd0, 1);
    wait_idle();
  endtask

  task automatic test_div();
    send(4'd11, 32'd100, 32'd7, 32'd0, 5'd10, 0, 0, 1, 32'd14, 1);
    wait_idle();
    send(4'd12, 32'd100, 32'd7, 32'd0, 5'd11, 0, 0, 1, 32'd2, 1);
    wait_idle();
    send(4'd11, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd12, 0, 0, 1,
         32'hFFFF_FFFF, 1);
    wait_idle();
    send(4'd12, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd13, 0, 0, 1,
         32'hDEAD_BEEF, 1);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      c = 4'(10 + (i % 3));
      a = $urandom;
      b = (i == 3) ? 32'($urandom_range(1, 9)) : $urandom;
      send(c, a, b, $urandom, 5'(i), 0, 1, 0, model(c, a, b), 1);
      wait_idle();
    end
  endtask

  task automatic test_flush();
    bit seen;
    seen = 0;
    send(4'd11, 32'd1000, 32'd3, 32'd0, 5'd14, 0, 0, 1, 32'd0, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_div got rdy=%b ov=%b want rdy=1 ov=0",
               in_ready, out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL flush_quiet got out_valid pulse want none");
    end
    @(posedge clk);
    #1;
    flush = 1'b1;
    send(4'd0, 32'd1, 32'd1, 32'd0, 5'd15, 0, 0, 1, 32'd0, 0);
    flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_input got ov=%b want 0", out_valid);
    end
    @(posedge clk);
    #1;
    send(4'd0, 32'd20, 32'd22, 32'd0, 5'd16, 0, 0, 1, 32'd42, 1);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || ALU_result !== 32'd42) begin
      n_err++;
      $display("FAIL after_flush got ov=%b res=%h want ov=1 res=0000002a",
               out_valid, ALU_result);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush_last();
    bit seen;
    seen = 0;
    send(4'd10, 32'd3, 32'd3, 32'd0, 5'd17, 0, 0, 1, 32'd9, 0);
    repeat (31) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_cmp++;
    if (seen || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_last got seen=%0b rdy=%b want seen=0 rdy=1",
               seen, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store();
    send(4'd0, 32'd0, 32'd0, 32'hCAFE_BABE, 5'd0, 0, 1, 0, 32'd0, 1);
    @(negedge clk);
    n_cmp++;
    if (MEM_W_EN !== 1'b1 || ST_value !== 32'hCAFE_BABE) begin
      n_err++;
      $display("FAIL store_cycle got w=%b st=%h want w=1 st=cafebabe",
               MEM_W_EN, ST_value);
    end
    @(negedge clk);
    n_cmp++;
    if (MEM_W_EN !== 1'b0 || out_valid !== 1'b0 ||
        ST_value !== 32'hCAFE_BABE) begin
      n_err++;
      $display("FAIL store_bubble got w=%b ov=%b st=%h want w=0 ov=0 st=cafebabe",
               MEM_W_EN, out_valid, ST_value);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_busy();
    bit seen;
    seen = 0;
    send(4'd10, 32'd6, 32'd7, 32'h99, 5'd21, 1, 1, 1, 32'd42, 0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, ALU_result, ST_value, dest,
         MEM_R_EN, MEM_W_EN, WB_EN, in_ready} !== {72'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_busy got ov=%b res=%h st=%h d=%0d ctrl=%b%b%b rdy=%b want zeros rdy=1",
               out_valid, ALU_result, ST_value, dest,
               MEM_R_EN, MEM_W_EN, WB_EN, in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL reset_discard got out_valid pulse want none");
    end
    @(posedge clk);
    #1;
    send(4'd5, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'd0, 5'd22, 0, 0, 1,
         32'h0F0F_F0F0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_alu();
    test_mul();
    test_div();
    test_flush();
    test_flush_last();
    test_store();
    test_reset_busy();
    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
